match_scheduler: RTL

- Best-of-N match controller above the master controller and the speed controller.
- Sequences consecutive rounds and chooses each round's type (normal, fake, speed).
- Tallies round wins per player from the one-shot round-win pulse, paces an intermission between rounds and declares the match winner.
- Runs on the divided 500 Hz game clock; its outputs drive round start, display selection and the victory path.

---
 rtl/match_scheduler_pkg.sv | 19 +
 rtl/match_scheduler_gap.sv | 36 +++
 rtl/match_scheduler.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/match_scheduler_pkg.sv
// rtl/match_scheduler_pkg.sv - shared state, round-type and width definitions for match_scheduler
package match_scheduler_pkg;

    localparam int WIN_W = 3;

    localparam logic [1:0] RT_NORMAL = 2'b00;
    localparam logic [1:0] RT_FAKE   = 2'b01;
    localparam logic [1:0] RT_SPEED  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_PLAY,
        ST_TALLY,
        ST_GAP,
        ST_DONE
    } state_e;

endpackage

// File: rtl/match_scheduler_gap.sv
// rtl/match_scheduler_gap.sv - gap_timer: loadable tick down-counter with an expiry flag
module gap_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Expiry is flagged on the tick that consumes the last count.
    assign done = tick && !load && (cnt_q == CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/match_scheduler.sv
// rtl/match_scheduler.sv - best-of-N round sequencer; MATCH_SUDDEN_DEATH_EN forces a speed decider round
module match_scheduler
    import match_scheduler_pkg::*;
#(
    parameter int ROUNDS_TO_WIN = 3,
    parameter int SPEED_EVERY   = 3,
    parameter int GAP_TICKS     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             slowen,
    input  logic             rand_bit,    // LFSR bit; "rand" is a reserved word
    input  logic             round_done,
    input  logic             round_right,
    input  logic             round_tie,
    output logic             round_go,
    output logic [1:0]       round_type,
    output logic [WIN_W-1:0] wins_left,
    output logic [WIN_W-1:0] wins_right,
    output logic [3:0]       round_num,
    output logic             match_over,
    output logic             match_right,
    output logic             busy
);

    localparam logic [WIN_W-1:0] WIN_TARGET = WIN_W'(ROUNDS_TO_WIN);
    localparam logic [3:0]       SPEED_MOD  = 4'(SPEED_EVERY);

    state_e           state_q, state_d;
    logic             round_go_q, round_go_d;
    logic [1:0]       round_type_q, round_type_d;
    logic [WIN_W-1:0] wins_left_q, wins_left_d;
    logic [WIN_W-1:0] wins_right_q, wins_right_d;
    logic [3:0]       round_num_q, round_num_d;
    logic             match_right_q, match_right_d;
    logic             res_tie_q, res_tie_d;
    logic             res_right_q, res_right_d;

    logic             gap_load;
    logic             gap_done;
    logic [1:0]       sel_type;
    logic [WIN_W-1:0] left_inc;
    logic [WIN_W-1:0] right_inc;
    logic             next_round;

    gap_timer #(.CNT_W(4)) u_gap (
        .clk      (clk),
        .rst      (rst),
        .load     (gap_load),
        .load_val (4'(GAP_TICKS)),
        .tick     (slowen && (state_q == ST_GAP)),
        .done     (gap_done)
    );

    always_comb begin
        sel_type = rand_bit ? RT_FAKE : RT_NORMAL;
        if ((round_num_q % SPEED_MOD) == 4'd0) begin
            sel_type = RT_SPEED;
        end
`ifdef MATCH_SUDDEN_DEATH_EN
        if ((wins_left_q == WIN_TARGET - 1'b1) && (wins_right_q == WIN_TARGET - 1'b1)) begin
            sel_type = RT_SPEED;
        end
`endif
    end

    assign left_inc  = wins_left_q + 1'b1;
    assign right_inc = wins_right_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        round_go_d    = 1'b0;
        round_type_d  = round_type_q;
        wins_left_d   = wins_left_q;
        wins_right_d  = wins_right_q;
        round_num_d   = round_num_q;
        match_right_d = match_right_q;
        res_tie_d     = res_tie_q;
        res_right_d   = res_right_q;
        gap_load      = 1'b0;
        next_round    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d       = ST_ARM;
                    wins_left_d   = '0;
                    wins_right_d  = '0;
                    round_num_d   = 4'd1;
                    match_right_d = 1'b0;
                end
            end
            ST_ARM: begin
                round_type_d = sel_type;
                round_go_d   = 1'b1;
                state_d      = ST_PLAY;
            end
            ST_PLAY: begin
                if (round_done) begin
                    res_tie_d   = round_tie;
                    res_right_d = round_right;
                    state_d     = ST_TALLY;
                end
            end
            ST_TALLY: begin
                if (res_tie_q) begin
                    next_round = 1'b1;
                end else if (res_right_q) begin
                    wins_right_d = right_inc;
                    if (right_inc == WIN_TARGET) begin
                        match_right_d = 1'b1;
                        state_d       = ST_DONE;
                    end else begin
                        next_round = 1'b1;
                    end
                end else begin
                    wins_left_d = left_inc;
                    if (left_inc == WIN_TARGET) begin
                        match_right_d = 1'b0;
                        state_d       = ST_DONE;
                    end else begin
                        next_round = 1'b1;
                    end
                end
                if (next_round) begin
                    round_num_d = (round_num_q == 4'd15) ? 4'd15 : round_num_q + 4'd1;
                    gap_load    = 1'b1;
                    state_d     = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_done) begin
                    state_d = ST_ARM;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            round_go_q    <= 1'b0;
            round_type_q  <= RT_NORMAL;
            wins_left_q   <= '0;
            wins_right_q  <= '0;
            round_num_q   <= 4'd0;
            match_right_q <= 1'b0;
            res_tie_q     <= 1'b0;
            res_right_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            round_go_q    <= round_go_d;
            round_type_q  <= round_type_d;
            wins_left_q   <= wins_left_d;
            wins_right_q  <= wins_right_d;
            round_num_q   <= round_num_d;
            match_right_q <= match_right_d;
            res_tie_q     <= res_tie_d;
            res_right_q   <= res_right_d;
        end
    end

    assign round_go    = round_go_q;
    assign round_type  = round_type_q;
    assign wins_left   = wins_left_q;
    assign wins_right  = wins_right_q;
    assign round_num   = round_num_q;
    assign match_over  = (state_q == ST_DONE);
    assign match_right = match_right_q;
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule
